cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
Host-side command player that sits directly upstream of RemoteComm, which feeds the KnightsTour UART.
- Buffers a list of 16-bit Knight commands, e.g. 16'h2000 calibrate gyro and 16'h4BF1 move east by one square.
- Issues the commands one at a time over RemoteComm's cmd/send_cmd/cmd_sent handshake.
- Waits for each response byte and advances only on a positive acknowledge (8'hA5).
- Enables scripted multi-move sequences in benches and on the FPGA host.

Parameters:
DEPTH, 16, command FIFO entries (power of 2, ≥2)
RESP_TIMEOUT, 32'd4_000_000, clocks to wait for resp_rdy after cmd_sent before flagging timeout
POS_ACK, 8'hA5, response value treated as success

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  push wr_cmd into FIFO this cycle
wr_cmd  in  16  command to queue
full  out  1  FIFO full
empty  out  1  FIFO empty
start  in  1  one-cycle pulse: begin issuing queued commands
abort  in  1  one-cycle pulse: stop after current handshake, flush FIFO
cmd  out  16  command presented to RemoteComm
send_cmd  out  1  one-cycle pulse to RemoteComm
cmd_sent  in  1  RemoteComm finished transmitting both bytes
resp_rdy  in  1  RemoteComm received response byte
resp  in  8  response byte
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: FIFO drained, all commands acked
err  out  1  sticky error, cleared by start or rst
err_code  out  2  01 NAK (resp≠POS_ACK), 10 timeout, 11 FIFO overflow
cmds_acked  out  8  count of acked commands since last start (saturates at 255)

Behaviour:
- Reset values: cmd=0, send_cmd=0, busy=0, done=0, err=0, err_code=0, cmds_acked=0; FIFO empty; state IDLE.
- FIFO: circular, DEPTH entries, pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Push while full: data dropped, err=1, err_code=11; the active sequence continues.
  - Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- State machine:
  - IDLE: on start, clear err/err_code/cmds_acked. If empty, pulse done next cycle and stay IDLE; else go to LOAD.
  - LOAD: pop FIFO head into cmd register (cmd stable from here through WAIT_RESP). Next state SEND.
  - SEND: send_cmd=1 for exactly one cycle. Next state WAIT_SENT.
  - WAIT_SENT: hold until cmd_sent=1. No timeout here (UART framing is bounded). Next state WAIT_RESP with timeout counter cleared.
  - WAIT_RESP: counter increments each clk.
    - resp_rdy with resp==POS_ACK: cmds_acked+1. If abort is pending, go to IDLE. Else if FIFO empty, pulse done and go to IDLE. Else go to LOAD.
    - resp_rdy with any other value: err=1, err_code=01, go to HALT.
    - Counter reaches RESP_TIMEOUT-1 without resp_rdy: err=1, err_code=10, go to HALT.
    - resp_rdy in the same cycle the counter expires: the response wins.
  - HALT: busy=0. Remaining FIFO contents retained. start resumes from the next unsent entry (the failed command is not replayed).
- busy=1 in LOAD, SEND, WAIT_SENT, WAIT_RESP.
- abort in any busy state sets a pending flag. The current handshake completes (RemoteComm cannot be interrupted mid-frame). The FIFO is flushed on return to IDLE; no done pulse is issued. abort in IDLE/HALT flushes the FIFO immediately.
- start while busy is ignored.
- rst mid-operation returns to IDLE in one cycle with reset values and an empty FIFO. send_cmd is never left high.
- resp_rdy/cmd_sent outside their wait states are ignored.

Optional Feature:
CMD_SEQ_RETRY_EN.
- Defined:
  - A timeout in WAIT_RESP re-issues the same cmd (back to SEND) once.
  - A second timeout on that command goes to HALT with err_code=10.
  - NAK is never retried.
  - The retry flag clears on every successful ack.
- Undefined: the first timeout halts.

Decomposition:
Package cmd_seq_pkg holds:
- state enum: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, HALT
- err_code constants: ERR_NONE, ERR_NAK, ERR_TIMEOUT, ERR_OVF
- opcode constants: CAL_GYRO=16'h2000, MOVE nibble 4'h4, MOVE_FANFARE nibble 4'h5
- POS_ACK default

One sub-module, cmd_fifo (synchronous-reset circular buffer with full/empty and a flush input), instantiated inside cmd_sequencer.

Test Plan:
1. Push 16'h2000, 16'h4BF1; start; model acks 8'hA5 each → two send_cmd pulses in order, cmd stable until cmd_sent, done pulse once, cmds_acked=2, err=0.
2. Push 3 cmds; second response 8'h5A → err=1, err_code=01, busy=0, cmds_acked=1; third cmd remains queued; start → only third cmd sent, done pulses.
3. RESP_TIMEOUT=100, no resp_rdy → err_code=10 exactly 100 clks after entering WAIT_RESP. With CMD_SEQ_RETRY_EN: same cmd resent once, then halt after second timeout.
4. Push DEPTH+1 cmds without start → full=1, err_code=11; start → exactly DEPTH cmds issued.
5. Start 4-cmd sequence, abort during first WAIT_SENT → first handshake completes, no further send_cmd, empty=1, no done pulse.
6. Assert rst during WAIT_RESP → next cycle all outputs at reset values, empty=1; a late resp_rdy is ignored.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and constants for the Knight command sequencer.
// FSM state encoding, error codes, Knight opcodes and the default ack byte.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_SENT = 3'd3,
        WAIT_RESP = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NAK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVF     = 2'b11;

    localparam logic [15:0] CAL_GYRO        = 16'h2000;
    localparam logic [3:0]  OP_MOVE         = 4'h4;
    localparam logic [3:0]  OP_MOVE_FANFARE = 4'h5;

    localparam logic [7:0] POS_ACK_DFLT = 8'hA5;

    // Saturating 8-bit increment for the ack counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: circular command buffer with synchronous reset and flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head is read into an output register on pop, so the array maps to RAM.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a push when a pop frees a slot the same cycle.
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign data_o  = rd_data_q;

    // Storage array: write port only, no reset so it stays RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer update and registered head read; flush discards all entries.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: plays a queued list of 16-bit Knight commands into RemoteComm,
// one handshake at a time, advancing only on a positive acknowledge.
// Optional build macro CMD_SEQ_RETRY_EN: a response timeout re-sends the
// same command once before halting.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int          DEPTH        = 16,
    parameter logic [31:0] RESP_TIMEOUT = 32'd4_000_000,
    parameter logic [7:0]  POS_ACK      = POS_ACK_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_cmd,
    output logic        full,
    output logic        empty,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  cmds_acked
);
    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  acked_q, acked_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [31:0] tmo_q, tmo_d;

    logic        fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [15:0] fifo_data;
    logic        busy_w, abort_pend, ovf, tmo_hit, retry_ok;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk    (clk),
        .rst_i  (rst),
        .push_i (wr_en),
        .data_i (wr_cmd),
        .pop_i  (fifo_pop),
        .flush_i(fifo_flush),
        .data_o (fifo_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign busy_w     = (state_q == LOAD) || (state_q == SEND) ||
                        (state_q == WAIT_SENT) || (state_q == WAIT_RESP);
    // An abort arriving in the very cycle the handshake finishes still counts.
    assign abort_pend = abort_q || abort;
    assign ovf        = wr_en && fifo_full && !fifo_pop;
    assign tmo_hit    = (tmo_q == RESP_TIMEOUT - 32'd1);

`ifdef CMD_SEQ_RETRY_EN
    logic retry_q, retry_d;

    // One retry credit per command: armed by a timeout, cleared on ack or new command.
    always_comb begin
        retry_d = retry_q;
        if (state_q == LOAD) begin
            retry_d = 1'b0;
        end else if (state_q == WAIT_RESP) begin
            if (resp_rdy && (resp == POS_ACK)) begin
                retry_d = 1'b0;
            end else if (!resp_rdy && tmo_hit) begin
                retry_d = 1'b1;
            end
        end
    end

    // Retry flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_ok = !retry_q && !abort_pend;
`else
    assign retry_ok = 1'b0;
`endif

    // Sequencer next-state, status and FIFO control.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        acked_d    = acked_q;
        done_d     = 1'b0;
        abort_d    = abort_q;
        tmo_d      = tmo_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (busy_w && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE, HALT: begin
                if (abort) begin
                    fifo_flush = 1'b1;
                end else if (start) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    acked_d    = '0;
                    if (fifo_empty) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                fifo_pop = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                state_d = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (cmd_sent) begin
                    state_d = WAIT_RESP;
                    tmo_d   = '0;
                end
            end
            WAIT_RESP: begin
                tmo_d = tmo_q + 32'd1;
                if (resp_rdy) begin
                    if (resp == POS_ACK) begin
                        acked_d = sat_inc8(acked_q);
                        if (abort_pend) begin
                            state_d    = IDLE;
                            fifo_flush = 1'b1;
                            abort_d    = 1'b0;
                        end else if (fifo_empty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NAK;
                        state_d    = HALT;
                        fifo_flush = abort_pend;
                        abort_d    = 1'b0;
                    end
                end else if (tmo_hit) begin
                    if (retry_ok) begin
                        state_d = SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        state_d    = HALT;
                        fifo_flush = abort_pend;
                        abort_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Overflow is flagged last so it is never masked by a start clearing err.
        if (ovf) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
        end
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            acked_q    <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            acked_q    <= acked_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cmd        = fifo_data;
    assign send_cmd   = (state_q == SEND);
    assign busy       = busy_w;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign cmds_acked = acked_q;
    assign full       = fifo_full;
    assign empty      = fifo_empty;

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed bench with a transaction-level model of the
// command player, compared against the DUT on every negative clock edge.
module tb_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_cmd = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        full, empty, send_cmd, busy, done, err;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [7:0]  cmds_acked;

    always #5 clk = ~clk;

    cmd_sequencer #(.DEPTH(DEPTH), .RESP_TIMEOUT(32'(TMO))) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd),
        .full(full), .empty(empty), .start(start), .abort(abort),
        .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .cmds_acked(cmds_acked)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic fail_bound(string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mq[$];
    logic [15:0] m_cur = '0;
    bit   m_active, m_pend, m_wsent, m_wresp, m_retry, m_err, m_send, m_done;
    logic [1:0] m_code = '0;
    int   m_acked, m_wait, m_snd_cd;
    bit   chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit was_active, was_wsent, flush_now;
        if (rst) begin
            mq.delete();
            m_cur = '0; m_active = 0; m_pend = 0; m_wsent = 0; m_wresp = 0;
            m_retry = 0; m_err = 0; m_code = '0; m_acked = 0; m_wait = 0;
            m_snd_cd = 0; m_send = 0; m_done = 0;
            chk_en = 1'b1;
        end else begin
            was_active = m_active;
            was_wsent  = m_wsent;
            flush_now  = 0;
            m_send = 0;
            m_done = 0;
            if (was_active && abort) m_pend = 1;
            if (m_snd_cd > 0) begin
                m_snd_cd--;
                if (m_snd_cd == 0) begin
                    m_send = 1; m_wsent = 1; m_retry = 0;
                    m_cur = mq.pop_front();
                end
            end
            if (m_wresp) begin
                if (resp_rdy) begin
                    m_wresp = 0;
                    if (resp == 8'hA5) begin
                        if (m_acked < 255) m_acked++;
                        m_retry = 0;
                        if (m_pend) begin
                            flush_now = 1; m_active = 0; m_pend = 0;
                        end else if (mq.size() == 0) begin
                            m_done = 1; m_active = 0;
                        end else begin
                            m_snd_cd = 1;
                        end
                    end else begin
                        m_err = 1; m_code = 2'b01; m_active = 0;
                        flush_now = m_pend; m_pend = 0;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_wresp = 0;
`ifdef CMD_SEQ_RETRY_EN
                        if (!m_retry && !m_pend) begin
                            m_retry = 1; m_send = 1; m_wsent = 1;
                        end else
`endif
                        begin
                            m_err = 1; m_code = 2'b10; m_active = 0;
                            flush_now = m_pend; m_pend = 0;
                        end
                    end
                end
            end else if (was_wsent && cmd_sent) begin
                m_wsent = 0; m_wresp = 1; m_wait = 0;
            end
            if (!was_active && abort) flush_now = 1;
            if (!was_active && start && !abort) begin
                m_err = 0; m_code = 2'b00; m_acked = 0;
                if (mq.size() == 0) m_done = 1;
                else begin
                    m_active = 1; m_snd_cd = 1;
                end
            end
            if (wr_en) begin
                if (mq.size() < DEPTH) mq.push_back(wr_cmd);
                else begin
                    m_err = 1; m_code = 2'b11;
                end
            end
            if (flush_now) mq.delete();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] sent_log[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       busy,       m_active);
            chk("send_cmd",   send_cmd,   m_send);
            chk("done",       done,       m_done);
            chk("err",        err,        m_err);
            chk("err_code",   err_code,   m_code);
            chk("cmds_acked", cmds_acked, 8'(m_acked));
            chk("empty",      empty,      mq.size() == 0);
            chk("full",       full,       mq.size() == DEPTH);
            chk("cmd",        cmd,        m_cur);
            if (send_cmd === 1'b1) sent_log.push_back(cmd);
            if (done === 1'b1) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] c);
        wr_en = 1'b1; wr_cmd = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (send_cmd === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_bound("send_wait");
        else tick();
    endtask

    task automatic handshake(input logic [7:0] r, input int dly,
                             input bit give_resp, input bit do_abort);
        bit ok;
        wait_send(ok);
        if (ok) begin
            if (do_abort) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            cmd_sent = 1'b1;
            tick();
            cmd_sent = 1'b0;
            if (give_resp) begin
                repeat (dly) tick();
                resp_rdy = 1'b1; resp = r;
                tick();
                resp_rdy = 1'b0;
                $display("txn cmd=%h resp=%h", cmd, r);
            end else begin
                $display("txn cmd=%h resp=none", cmd);
            end
        end
    endtask

    task automatic measure(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (err === 1'b1 || send_cmd === 1'b1) break;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base, d0, n;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_empty", empty, 1);
        chk("rst_acked", cmds_acked, 0);

        // 1: two acked commands
        push(cmd_seq_pkg::CAL_GYRO);
        push(16'h4BF1);
        base = sent_log.size(); d0 = done_cnt;
        pulse_start();
        handshake(8'hA5, 3, 1, 0);
        handshake(8'hA5, 2, 1, 0);
        repeat (3) tick();
        chk("t1_first", sent_log[base], 16'h2000);
        chk("t1_second", sent_log[base+1], 16'h4BF1);
        chk("t1_nsent", sent_log.size() - base, 2);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_acked", cmds_acked, 2);
        chk("t1_err", err, 0);

        // 2: NAK on the second of three, then resume
        push(16'h4AF1); push(16'h5BF1); push(16'h4CF1);
        pulse_start();
        handshake(8'hA5, 1, 1, 0);
        handshake(8'h5A, 2, 1, 0);
        repeat (3) tick();
        chk("t2_err", err, 1);
        chk("t2_code", err_code, 2'b01);
        chk("t2_busy", busy, 0);
        chk("t2_acked", cmds_acked, 1);
        chk("t2_empty", empty, 0);
        base = sent_log.size(); d0 = done_cnt;
        pulse_start();
        handshake(8'hA5, 1, 1, 0);
        repeat (3) tick();
        chk("t2_resume_cmd", sent_log[base], 16'h4CF1);
        chk("t2_resume_n", sent_log.size() - base, 1);
        chk("t2_resume_done", done_cnt - d0, 1);
        chk("t2_resume_err", err, 0);

        // 3: response timeout
        push(16'h4DF1);
        pulse_start();
        handshake(8'h00, 0, 0, 0);
        measure(n);
        chk("t3_tmo_cycles", n, TMO);
`ifdef CMD_SEQ_RETRY_EN
        chk("t3_resend", send_cmd, 1);
        chk("t3_resend_cmd", cmd, 16'h4DF1);
        handshake(8'h00, 0, 0, 0);
        measure(n);
        chk("t3_tmo2_cycles", n, TMO);
`endif
        chk("t3_code", err_code, 2'b10);
        chk("t3_busy", busy, 0);

        // 4: overflow, then exactly DEPTH commands issued
        for (int i = 0; i <= DEPTH; i++) push(16'h4000 + 16'(i));
        chk("t4_full", full, 1);
        chk("t4_code", err_code, 2'b11);
        base = sent_log.size(); d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) handshake(8'hA5, 1, 1, 0);
        repeat (3) tick();
        chk("t4_nsent", sent_log.size() - base, DEPTH);
        chk("t4_last", sent_log[base+DEPTH-1], 16'h4003);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_acked", cmds_acked, DEPTH);

        // start with nothing queued: done pulse on the next cycle
        pulse_start();
        chk("empty_start_done", done, 1);

        // 5: abort during first WAIT_SENT
        for (int i = 0; i < 4; i++) push(16'h5100 + 16'(i));
        base = sent_log.size(); d0 = done_cnt;
        pulse_start();
        handshake(8'hA5, 2, 1, 1);
        repeat (10) tick();
        chk("t5_nsent", sent_log.size() - base, 1);
        chk("t5_empty", empty, 1);
        chk("t5_done", done_cnt - d0, 0);
        chk("t5_acked", cmds_acked, 1);

        // 6: reset during WAIT_RESP, late response ignored
        push(16'h4EF1); push(16'h4FF1);
        pulse_start();
        handshake(8'h00, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_empty", empty, 1);
        chk("t6_cmd", cmd, 0);
        chk("t6_send", send_cmd, 0);
        resp_rdy = 1'b1; resp = 8'hA5;
        tick();
        resp_rdy = 1'b0;
        repeat (2) tick();
        chk("t6_late_acked", cmds_acked, 0);
        chk("t6_late_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
